// File: rtl/aes_pkg.sv
// Shared AES byte-substitution tables and lookup helpers.
// Holds the forward and inverse S-box constants used by every lane.
package aes_pkg;

  localparam int MAX_LANES = 16;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox_f(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: a single byte in, its substitution out.
// Build option INV_SBOX_EN adds the inverse table, selected by inv.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] data,
  output logic [7:0] sub
);

`ifdef INV_SBOX_EN
  assign sub = inv ? inv_sbox_f(data) : sbox_f(data);
`else
  // Only the forward table exists, so the select has nothing to steer.
  logic unused_inv;
  assign unused_inv = inv;
  assign sub = sbox_f(data);
`endif

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Pipelined SubBytes engine with valid/ready flow control.
// Lookup feeds stage 0; later stages only carry the result toward out_*.
// Build option INV_SBOX_EN enables per-transaction inverse substitution.
module aes_subbytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_inv,
  input  logic [8*LANES-1:0]                 in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_inv,
  output logic [8*LANES-1:0]                 out_data,
  output logic [$clog2(PIPE_STAGES+1)-1:0]   occupancy
);

  localparam int OW = $clog2(PIPE_STAGES + 1);

  typedef struct packed {
    logic               v;
    logic               inv;
    logic [8*LANES-1:0] d;
  } stage_t;

  stage_t                 stg [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] adv;
  logic                   adv_nxt;
  logic [8*LANES-1:0]     sub_data;
  logic                   inv_sel;
  logic                   in_fire;
  logic                   out_fire;

`ifdef INV_SBOX_EN
  assign inv_sel = in_inv;
`else
  assign inv_sel = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .inv  (inv_sel),
      .data (in_data[8*i +: 8]),
      .sub  (sub_data[8*i +: 8])
    );
  end

  // Advance chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    adv     = '0;
    adv_nxt = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      adv[k]  = !stg[k].v || adv_nxt;
      adv_nxt = adv[k];
    end
  end

  assign in_ready  = adv[0] || rst;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = stg[PIPE_STAGES-1].v;
  assign out_inv   = stg[PIPE_STAGES-1].inv;
  assign out_data  = stg[PIPE_STAGES-1].d;
  assign out_fire  = out_valid && out_ready;

  // Stage registers; payload only moves with a valid beat so out_data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stg[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        stg[0].v <= in_valid;
        if (in_valid) begin
          stg[0].d   <= sub_data;
          stg[0].inv <= inv_sel;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (adv[k]) begin
          stg[k].v <= stg[k-1].v;
          if (stg[k-1].v) begin
            stg[k].d   <= stg[k-1].d;
            stg[k].inv <= stg[k-1].inv;
          end
        end
      end
    end
  end

  // Occupancy tracks beats in flight: up on accept, down on emit, flat on both.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OW'(1);
    end else if (!in_fire && out_fire) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Self-checking bench for aes_subbytes_pipe with LANES=4, PIPE_STAGES=2.
// Expected S-box values come from a GF(2^8) inverse + affine model built here.
// Define INV_SBOX_EN to exercise the inverse-table build.
module tb_aes_subbytes_pipe;

  localparam int LANES = 4;
  localparam int PIPE_STAGES = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_inv;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_inv;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  aes_subbytes_pipe #(.LANES(LANES), .PIPE_STAGES(PIPE_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inv   (out_inv),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] a);
    logic [7:0] g, s;
    g = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) g = 8'(b);
    end
    s = g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_fwd[w[8*i +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic inv, input logic [31:0] d);
    in_valid = v;
    in_inv   = inv;
    in_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [31:0] beat_a, beat_b, beat_c;
    int acc, emi;

    for (int x = 0; x < 256; x++) begin
      ref_fwd[x] = model_sbox(8'(x));
      ref_inv[ref_fwd[x]] = 8'(x);
    end

    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_out_inv", {31'b0, out_inv}, 32'd0);
    checkOutput("rst_occupancy", {30'b0, occupancy}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] forward path");
    applyStimulus(1'b1, 1'b0, 32'h5310_0100);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("fwd_lat_valid0", {31'b0, out_valid}, 32'd0);
    tick();
    checkOutput("fwd_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("fwd_data", out_data, 32'hEDCA_7C63);
    checkOutput("fwd_inv", {31'b0, out_inv}, 32'd0);
    tick();
    checkOutput("fwd_valid_once", {31'b0, out_valid}, 32'd0);

`ifdef INV_SBOX_EN
    $display("[TB] inverse path");
    applyStimulus(1'b1, 1'b1, 32'hEDCA_7C63);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("inv_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("inv_data", out_data, 32'h5310_0100);
    checkOutput("inv_inv", {31'b0, out_inv}, 32'd1);
    checkOutput("inv_model", out_data,
                {ref_inv[8'hED], ref_inv[8'hCA], ref_inv[8'h7C], ref_inv[8'h63]});
    tick();
`else
    $display("[TB] inverse select ignored");
    applyStimulus(1'b1, 1'b1, 32'h0000_0063);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("noinv_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("noinv_data", out_data, 32'h6363_63FB);
    checkOutput("noinv_inv", {31'b0, out_inv}, 32'd0);
    tick();
`endif

    $display("[TB] exhaustive stream");
    for (int t = 0; t <= 66; t++) begin
      acc = (t < 64) ? t : 64;
      emi = (t - 2 < 0) ? 0 : ((t - 2 > 64) ? 64 : t - 2);
      checkOutput("ex_occupancy", {30'b0, occupancy}, 32'(acc - emi));
      if (t >= 2 && t <= 65) begin
        checkOutput("ex_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("ex_data", out_data,
                    {ref_fwd[8'(4*(t-2)+3)], ref_fwd[8'(4*(t-2)+2)],
                     ref_fwd[8'(4*(t-2)+1)], ref_fwd[8'(4*(t-2))]});
      end else begin
        checkOutput("ex_idle_valid", {31'b0, out_valid}, 32'd0);
      end
      if (t < 64) begin
        applyStimulus(1'b1, 1'b0, {8'(4*t+3), 8'(4*t+2), 8'(4*t+1), 8'(4*t)});
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0);
      end
      #1;
      checkOutput("ex_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
    end

    $display("[TB] backpressure");
    beat_a = 32'h0011_2233;
    beat_b = 32'h4455_6677;
    beat_c = 32'h8899_AABB;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, (k == 0) ? beat_a : ((k == 1) ? beat_b : beat_c));
      #1;
      checkOutput("bp_in_ready", {31'b0, in_ready}, (k < 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        checkOutput("bp_full_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_hold_data", out_data, ref_word(beat_a));
        checkOutput("bp_full_occ", {30'b0, occupancy}, 32'd2);
      end
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("bp_still_data", out_data, ref_word(beat_a));
    checkOutput("bp_still_occ", {30'b0, occupancy}, 32'd2);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    checkOutput("bp_second_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_second_data", out_data, ref_word(beat_b));
    checkOutput("bp_second_occ", {30'b0, occupancy}, 32'd1);
    tick();
    checkOutput("bp_drained_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_drained_occ", {30'b0, occupancy}, 32'd0);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b1, 1'b0, 32'hCAFE_F00D);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("mr_pre_occ", {30'b0, occupancy}, 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("mr_rst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    checkOutput("mr_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mr_occ", {30'b0, occupancy}, 32'd0);
    checkOutput("mr_data", out_data, 32'h0);
    checkOutput("mr_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("mr_no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
